// File: rtl/pe_operand_sel.sv
// N-input valid/ready operand selector feeding a 2-entry registered output buffer.
// An out-of-range select never transfers data and raises a sticky error flag.
module pe_operand_sel #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_IN  = 3,
    parameter int unsigned SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  flush,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sel_err
);

    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] buf0_q, buf0_d;
    logic [WIDTH-1:0] buf1_q, buf1_d;
    logic             sel_err_q, sel_err_d;

    logic             sel_ok;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] sel_data;

    assign sel_ok = 32'(sel) < N_IN;

    // Ready is derived from occupancy only, never from out_ready.
    always_comb begin
        in_ready = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (32'(sel) == i) begin
                in_ready[i] = sel_ok && (count_q != 2'd2) && !flush && !rst;
                sel_data    = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign push      = |(in_valid & in_ready);
    assign out_valid = count_q != 2'd0;
    assign pop       = out_valid && out_ready;
    assign out_data  = buf0_q;
    assign sel_err   = sel_err_q;

    always_comb begin
        count_d   = count_q;
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        sel_err_d = sel_err_q;
        if (flush) begin
            // Contents are left in place so out_data keeps its last value.
            count_d   = 2'd0;
            sel_err_d = 1'b0;
        end else begin
            if (!sel_ok) begin
                sel_err_d = 1'b1;
            end
            case (count_q)
                2'd0: begin
                    if (push) begin
                        buf0_d  = sel_data;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        buf0_d = sel_data;
                    end else if (push) begin
                        buf1_d  = sel_data;
                        count_d = 2'd2;
                    end else if (pop) begin
                        count_d = 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        buf0_d  = buf1_q;
                        count_d = 2'd1;
                    end
                end
                default: begin
                    count_d = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= 2'd0;
            buf0_q    <= '0;
            buf1_q    <= '0;
            sel_err_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            buf0_q    <= buf0_d;
            buf1_q    <= buf1_d;
            sel_err_q <= sel_err_d;
        end
    end

endmodule
